// File: rtl/wb_cdb_arbiter.sv
// Writeback arbiter: three execute lanes feed per-lane FIFOs,
// two heads per cycle are granted round-robin onto a registered CDB.
module wb_cdb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int PREG_W     = 6,
  parameter int ROB_W      = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              lane0_valid_in,
  output logic              lane0_ready_out,
  input  logic [31:0]       lane0_pc_in,
  input  logic [31:0]       lane0_result_in,
  input  logic [PREG_W-1:0] lane0_dest_in,
  input  logic [ROB_W-1:0]  lane0_rob_in,
  input  logic              lane1_valid_in,
  output logic              lane1_ready_out,
  input  logic [31:0]       lane1_pc_in,
  input  logic [31:0]       lane1_result_in,
  input  logic [PREG_W-1:0] lane1_dest_in,
  input  logic [ROB_W-1:0]  lane1_rob_in,
  input  logic              lane2_valid_in,
  output logic              lane2_ready_out,
  input  logic [31:0]       lane2_pc_in,
  input  logic [31:0]       lane2_result_in,
  input  logic [PREG_W-1:0] lane2_dest_in,
  input  logic [ROB_W-1:0]  lane2_rob_in,
  output logic              cdb0_valid_out,
  output logic [31:0]       cdb0_pc_out,
  output logic [31:0]       cdb0_result_out,
  output logic [PREG_W-1:0] cdb0_dest_out,
  output logic [ROB_W-1:0]  cdb0_rob_out,
  output logic              cdb1_valid_out,
  output logic [31:0]       cdb1_pc_out,
  output logic [31:0]       cdb1_result_out,
  output logic [PREG_W-1:0] cdb1_dest_out,
  output logic [ROB_W-1:0]  cdb1_rob_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       res;
    logic [PREG_W-1:0] dest;
    logic [ROB_W-1:0]  rob;
  } ent_t;

  ent_t          din   [3];
  ent_t          mem_q [3][FIFO_DEPTH];
  logic [PW-1:0] wp_q  [3];
  logic [PW-1:0] rp_q  [3];
  logic [CW-1:0] cnt_q [3];
  logic [2:0]    vin;
  logic [2:0]    rdy;
  logic [2:0]    push;
  logic [2:0]    pop;
  logic [1:0]    rr_q;
  logic [1:0]    rr_d;
  logic          g0v;
  logic          g1v;
  logic [1:0]    g0;
  logic [1:0]    g1;
  logic [2:0]    s;
  logic [1:0]    l;
  logic [1:0]    cv_q;
  ent_t          ce_q  [2];

  assign vin = {lane2_valid_in, lane1_valid_in, lane0_valid_in};

  assign din[0] = {lane0_pc_in, lane0_result_in,
                   lane0_dest_in, lane0_rob_in};
  assign din[1] = {lane1_pc_in, lane1_result_in,
                   lane1_dest_in, lane1_rob_in};
  assign din[2] = {lane2_pc_in, lane2_result_in,
                   lane2_dest_in, lane2_rob_in};

  // Ready looks only at the registered count; reset forces it low.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rdy[k]  = rstn & (cnt_q[k] != FULL);
      push[k] = vin[k] & rdy[k];
    end
  end

  // Round-robin scan from rr_q; first two non-empty lanes win.
  always_comb begin
    g0v  = 1'b0;
    g1v  = 1'b0;
    g0   = 2'd0;
    g1   = 2'd0;
    s    = 3'd0;
    l    = 2'd0;
    rr_d = rr_q;
    for (int i = 0; i < 3; i++) begin
      s = {1'b0, rr_q} + 3'(i);
      l = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
      if (cnt_q[l] != '0) begin
        if (!g0v) begin
          g0v  = 1'b1;
          g0   = l;
          rr_d = (l == 2'd2) ? 2'd0 : l + 2'd1;
        end else if (!g1v) begin
          g1v  = 1'b1;
          g1   = l;
          rr_d = (l == 2'd2) ? 2'd0 : l + 2'd1;
        end
      end
    end
  end

  // Granted heads leave their FIFO at the edge the CDB loads.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      pop[k] = (g0v && (g0 == 2'(k)))
             | (g1v && (g1 == 2'(k)));
    end
  end

  // FIFO storage; contents need no reset, counts gate validity.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!flush && push[k]) begin
        mem_q[k][wp_q[k]] <= din[k];
      end
    end
  end

  // Pointers, counts, rr pointer and CDB registers.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      rr_q    <= 2'd0;
      cv_q    <= 2'b00;
      ce_q[0] <= '0;
      ce_q[1] <= '0;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= '0;
        wp_q[k]  <= '0;
        rp_q[k]  <= '0;
      end
    end else begin
      rr_q    <= rr_d;
      cv_q    <= {g1v, g0v};
      ce_q[0] <= g0v ? mem_q[g0][rp_q[g0]] : '0;
      ce_q[1] <= g1v ? mem_q[g1][rp_q[g1]] : '0;
      for (int k = 0; k < 3; k++) begin
        if (push[k]) wp_q[k] <= wp_q[k] + 1'b1;
        if (pop[k])  rp_q[k] <= rp_q[k] + 1'b1;
        cnt_q[k] <= cnt_q[k] + CW'(push[k])
                             - CW'(pop[k]);
      end
    end
  end

  assign lane0_ready_out = rdy[0];
  assign lane1_ready_out = rdy[1];
  assign lane2_ready_out = rdy[2];

  assign cdb0_valid_out  = cv_q[0];
  assign cdb0_pc_out     = ce_q[0].pc;
  assign cdb0_result_out = ce_q[0].res;
  assign cdb0_dest_out   = ce_q[0].dest;
  assign cdb0_rob_out    = ce_q[0].rob;
  assign cdb1_valid_out  = cv_q[1];
  assign cdb1_pc_out     = ce_q[1].pc;
  assign cdb1_result_out = ce_q[1].res;
  assign cdb1_dest_out   = ce_q[1].dest;
  assign cdb1_rob_out    = ce_q[1].rob;

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// Bench for wb_cdb_arbiter: per-lane expected queues drained by a
// CDB monitor, plus directed port/ordering checks.
module tb_wb_cdb_arbiter;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic [5:0]  dst;
    logic [5:0]  rob;
  } ent_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic [2:0]  vld;
  ent_t        lin [3];
  logic        r0, r1, r2;
  logic        c0v, c1v;
  logic [31:0] c0pc, c0res, c1pc, c1res;
  logic [5:0]  c0dst, c0rob, c1dst, c1rob;

  ent_t exp_q [3][$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;
  logic win_en  = 1'b0;
  int   bc      [3];
  int   miss    [3];
  int   maxmiss [3];
  logic [5:0] seq [3];
  logic saw_low;

  always #5 clk = ~clk;

  wb_cdb_arbiter #(.FIFO_DEPTH(2), .PREG_W(6), .ROB_W(6)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .lane0_valid_in(vld[0]), .lane0_ready_out(r0),
    .lane0_pc_in(lin[0].pc), .lane0_result_in(lin[0].res),
    .lane0_dest_in(lin[0].dst), .lane0_rob_in(lin[0].rob),
    .lane1_valid_in(vld[1]), .lane1_ready_out(r1),
    .lane1_pc_in(lin[1].pc), .lane1_result_in(lin[1].res),
    .lane1_dest_in(lin[1].dst), .lane1_rob_in(lin[1].rob),
    .lane2_valid_in(vld[2]), .lane2_ready_out(r2),
    .lane2_pc_in(lin[2].pc), .lane2_result_in(lin[2].res),
    .lane2_dest_in(lin[2].dst), .lane2_rob_in(lin[2].rob),
    .cdb0_valid_out(c0v), .cdb0_pc_out(c0pc),
    .cdb0_result_out(c0res), .cdb0_dest_out(c0dst),
    .cdb0_rob_out(c0rob),
    .cdb1_valid_out(c1v), .cdb1_pc_out(c1pc),
    .cdb1_result_out(c1res), .cdb1_dest_out(c1dst),
    .cdb1_rob_out(c1rob)
  );

  function automatic ent_t mk(input int k, input logic [5:0] r);
    ent_t e;
    e.pc  = 32'h1000 * (k + 1) + {24'd0, r, 2'b00};
    e.res = 32'hA5A5_0000 ^ e.pc;
    e.dst = r ^ 6'(k);
    e.rob = r;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Drive one cycle; record accepted pushes; wait past the edge.
  task automatic step(input logic [2:0] v, input logic fl,
                      input logic rs, input logic au);
    logic [2:0] rd;
    if (au) for (int k = 0; k < 3; k++) lin[k] = mk(k, seq[k]);
    vld   = v;
    flush = fl;
    rstn  = rs;
    #1;
    rd = {r2, r1, r0};
    for (int k = 0; k < 3; k++) begin
      if (v[k] && rd[k] && !fl && rs) begin
        exp_q[k].push_back(lin[k]);
        if (au) seq[k] = seq[k] + 6'd1;
      end
    end
    @(posedge clk);
    #1;
    vld = 3'b000;
    if (fl || !rs) for (int k = 0; k < 3; k++) exp_q[k].delete();
  endtask

  // Monitor: every broadcast must match the head of some lane queue.
  always @(negedge clk) begin
    ent_t e;
    logic v;
    int   f;
    logic [2:0] gr;
    if (mon_en) begin
      gr = 3'b000;
      n_tests++;
      if (c1v && !c0v) begin
        n_fail++;
        $display("FAIL cdb1_without_cdb0: got c0v=%0b c1v=%0b",
                 c0v, c1v);
      end
      for (int p = 0; p < 2; p++) begin
        v = (p == 0) ? c0v : c1v;
        e = (p == 0) ? {c0pc, c0res, c0dst, c0rob}
                     : {c1pc, c1res, c1dst, c1rob};
        n_tests++;
        if (v) begin
          f = -1;
          for (int k = 0; k < 3; k++)
            if (f < 0 && exp_q[k].size() > 0 && exp_q[k][0] == e)
              f = k;
          if (f < 0) begin
            n_fail++;
            $display("FAIL cdb%0d_unexpected: got pc=%0h rob=%0d",
                     p, e.pc, e.rob);
          end else begin
            void'(exp_q[f].pop_front());
            bc[f]++;
            gr[f] = 1'b1;
          end
        end else if (e !== '0) begin
          n_fail++;
          $display("FAIL cdb%0d_idle_payload: got %0h want 0",
                   p, e);
        end
      end
      if (win_en) begin
        for (int k = 0; k < 3; k++) begin
          miss[k] = gr[k] ? 0 : miss[k] + 1;
          if (miss[k] > maxmiss[k]) maxmiss[k] = miss[k];
        end
      end
    end
  end

  initial begin
    rstn = 1'b0;
    flush = 1'b0;
    vld = 3'b000;
    for (int k = 0; k < 3; k++) begin
      lin[k] = '0;
      bc[k] = 0;
      miss[k] = 0;
      maxmiss[k] = 0;
      seq[k] = 6'(16 * k);
    end

    // Reset state
    step(3'b000, 1'b0, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk("rst_ready", {r2, r1, r0}, 3'b000);
    chk("rst_cdbv", {c1v, c0v}, 2'b00);
    chk("rst_cdb0", {c0pc, c0res, c0dst, c0rob}, 0);
    mon_en = 1'b1;

    // Single lane, lane1
    lin[1] = '{pc: 32'h100, res: 32'h2A, dst: 6'd5, rob: 6'd3};
    step(3'b010, 1'b0, 1'b1, 1'b0);
    chk("single_early", c0v, 1'b0);
    step(3'b000, 1'b0, 1'b1, 1'b0);
    chk("single_v0", c0v, 1'b1);
    chk("single_f", {c0pc, c0res, c0dst, c0rob},
        {32'h100, 32'h2A, 6'd5, 6'd3});
    chk("single_v1", c1v, 1'b0);

    // rr_ptr=2 now: lane2 then lane0, then lane1 alone
    for (int k = 0; k < 3; k++) lin[k] = mk(k, 6'(20 + k));
    step(3'b111, 1'b0, 1'b1, 1'b0);
    step(3'b000, 1'b0, 1'b1, 1'b0);
    chk("rr2_c0", {c0v, c0rob}, {1'b1, 6'd22});
    chk("rr2_c1", {c1v, c1rob}, {1'b1, 6'd20});
    step(3'b000, 1'b0, 1'b1, 1'b0);
    chk("rr2_c0b", {c0v, c0rob}, {1'b1, 6'd21});
    chk("rr2_c1b", c1v, 1'b0);

    // Flush resets rr_ptr; three-way contention from rr=0
    step(3'b000, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) lin[k] = mk(k, 6'(10 + k));
    step(3'b111, 1'b0, 1'b1, 1'b0);
    step(3'b000, 1'b0, 1'b1, 1'b0);
    chk("tri_c0", {c0v, c0rob}, {1'b1, 6'd10});
    chk("tri_c1", {c1v, c1rob}, {1'b1, 6'd11});
    step(3'b000, 1'b0, 1'b1, 1'b0);
    chk("tri_c0b", {c0v, c0rob}, {1'b1, 6'd12});
    chk("tri_c1b", c1v, 1'b0);
    lin[1] = mk(1, 6'd30);
    lin[2] = mk(2, 6'd31);
    step(3'b110, 1'b0, 1'b1, 1'b0);
    step(3'b000, 1'b0, 1'b1, 1'b0);
    chk("rr0_c0", {c0v, c0rob}, {1'b1, 6'd30});
    chk("rr0_c1", {c1v, c1rob}, {1'b1, 6'd31});

    // Backpressure with all lanes pushing
    saw_low = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(3'b111, 1'b0, 1'b1, 1'b1);
      if (!r0) saw_low = 1'b1;
    end
    chk("bp_ready0_low", saw_low, 1'b1);
    for (int i = 0; i < 8; i++) step(3'b000, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp_drained%0d", k), exp_q[k].size(), 0);

    // Fairness over 30 saturated cycles
    for (int i = 0; i < 4; i++) step(3'b111, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      bc[k] = 0;
      miss[k] = 0;
      maxmiss[k] = 0;
    end
    win_en = 1'b1;
    for (int i = 0; i < 30; i++) step(3'b111, 1'b0, 1'b1, 1'b1);
    win_en = 1'b0;
    chk("fair_total", bc[0] + bc[1] + bc[2], 60);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("fair_lane%0d", k), bc[k], 20);
      chk($sformatf("starve_lane%0d", k), maxmiss[k] > 1, 1'b0);
    end

    // Flush with valids asserted
    step(3'b111, 1'b1, 1'b1, 1'b1);
    chk("flush_cdbv", {c1v, c0v}, 2'b00);
    chk("flush_ready", {r2, r1, r0}, 3'b111);
    for (int i = 0; i < 4; i++) step(3'b000, 1'b0, 1'b1, 1'b0);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) step(3'b111, 1'b0, 1'b1, 1'b1);
    chk("pre_rst_c0v", c0v, 1'b1);
    step(3'b111, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_cdbv", {c1v, c0v}, 2'b00);
    chk("mid_rst_pay", {c0pc, c0res, c1pc, c1res}, 0);
    chk("mid_rst_ready", {r2, r1, r0}, 3'b000);
    lin[0] = mk(0, 6'd40);
    lin[2] = mk(2, 6'd42);
    step(3'b101, 1'b0, 1'b1, 1'b0);
    step(3'b000, 1'b0, 1'b1, 1'b0);
    chk("post_rst_c0", {c0v, c0rob}, {1'b1, 6'd40});
    chk("post_rst_c1", {c1v, c1rob}, {1'b1, 6'd42});
    for (int i = 0; i < 4; i++) step(3'b000, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      chk($sformatf("final_drained%0d", k), exp_q[k].size(), 0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_cdb_arbiter.md
Name: wb_cdb_arbiter

Overview:
- Writeback arbiter between the three-lane execute-stage pipeline register and a 2-port common data bus (CDB) to the ROB/reservation stations.
- Each lane result (PC, result, physical dest, ROB number) enters a small per-lane FIFO.
- Each cycle, up to two FIFO heads are granted round-robin onto registered CDB ports.
- Backpressure to execute lanes via per-lane ready; flush drops all pending results.

Parameters:
- FIFO_DEPTH, 2, entries per lane FIFO; power of 2, minimum 2.
- PREG_W, 6, physical destination register width.
- ROB_W, 6, ROB index width.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  synchronous active-low reset
- flush  in  1  synchronous pipeline flush (mispredict/exception)
- laneK_valid_in  in  1  (K=0,1,2) lane K result valid
- laneK_ready_out  out  1  lane K FIFO can accept
- laneK_pc_in  in  32  lane K instruction PC
- laneK_result_in  in  32  lane K ALU/address result
- laneK_dest_in  in  PREG_W  lane K physical dest
- laneK_rob_in  in  ROB_W  lane K ROB number
- cdbJ_valid_out  out  1  (J=0,1) CDB port J broadcast valid
- cdbJ_pc_out  out  32  broadcast PC
- cdbJ_result_out  out  32  broadcast result
- cdbJ_dest_out  out  PREG_W  broadcast physical dest
- cdbJ_rob_out  out  ROB_W  broadcast ROB number

Behaviour:
- Reset:
  - Synchronous, active-low.
  - While rstn=0 at a rising edge: all FIFO counts and pointers go to 0, rr_ptr goes to 0, and every cdb output (valid and payload) goes to 0.
  - laneK_ready_out is forced to 0 while rstn=0.
  - Reset overrides flush.
- Enqueue:
  - laneK_ready_out = (countK != FIFO_DEPTH).
  - Ready is combinational from registered count only; it does not look at same-cycle dequeue.
  - Entry is written at the edge where valid_in && ready_out.
  - Offering valid with ready=0 has no effect; the producer must hold its data.
- Grant (combinational, registered at edge):
  - Candidates are lanes with countK>0.
  - Scan lanes in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - First candidate found goes to cdb0; second goes to cdb1; a third waits.
  - Granted heads are popped at the same edge the cdb registers load.
- Latency: a result accepted at edge N into an empty FIFO appears on the CDB after edge N+1. Minimum latency is 1 cycle; there is no bypass.
- CDB outputs:
  - Registered.
  - An ungranted port loads valid=0 with all payload fields 0.
  - If only one grant occurs, it always uses cdb0, and cdb1 is invalid.
  - No CDB stall input exists; consumers accept every broadcast.
- Round-robin pointer:
  - If at least one grant occurs, rr_ptr becomes (index of last granted lane + 1) mod 3.
  - If there are no grants, rr_ptr is unchanged.
  - rr_ptr values are 0..2 only.
- Ordering:
  - Within a lane, strict FIFO order.
  - Across lanes, no ordering guarantee.
- Simultaneous push and pop on one lane: count unchanged. This is legal when full, but ready is already 0 in that cycle, so no push occurs.
- Pointer wrap: read and write pointers wrap mod FIFO_DEPTH.
- dest=0 results are broadcast like any other result; there is no special case.
- Flush:
  - At the edge with flush=1 (rstn=1): all counts and pointers clear, cdb valids and payloads go to 0, and rr_ptr goes to 0.
  - Inputs offered in the flush cycle are discarded even if ready=1.
  - No grant is made in the flush cycle.
  - Ready reasserts in the next cycle.
- Invariants:
  - No result is ever broadcast twice.
  - At most 2 broadcasts per cycle.
  - countK never exceeds FIFO_DEPTH.

Test Plan:
- Single lane: after reset, lane1 pushes pc=0x100, result=0x2A, dest=5, rob=3 at edge N. Required: cdb0_valid=1 with those fields after edge N+1; cdb1_valid=0; rr_ptr=2.
- Three-way contention: all lanes push in one cycle (rob 10,11,12) with rr_ptr=0. Required: next cycle cdb0=rob10 and cdb1=rob11, rr_ptr=2; the following cycle cdb0=rob12 alone, rr_ptr=0.
- Backpressure: lane0 pushes every cycle while lanes 1/2 push continuously. Required: lane0_ready_out drops when its count reaches 2; no entry is lost or duplicated; lane0 rob order is preserved on the CDB.
- Fairness: all three lanes saturated for 30 cycles. Required: 60 broadcasts, each lane granted 20 times, and no lane is starved for more than 1 consecutive cycle.
- Flush: all FIFOs full and new valids asserted with flush=1. Required: next cycle all cdb valids=0, all ready_out=1, and no flushed rob number ever appears.
- Reset mid-operation: rstn=0 for one edge while the FIFOs are partially full and cdb0 is valid. Required: all outputs 0, and afterwards the first push is broadcast via cdb0 with rr_ptr starting at 0.
